// File: rtl/logic_wb_buffer.sv
// ---------------------------------------------------------------------------
// logic_wb_buffer
//
// Two-entry in-order write-back buffer between the logic unit and the
// register-file write port. Each accepted result {in_rd, in_data} is queued
// and presented as a register-file write request until the write port takes
// it. Results addressed to r0 complete their handshake but are not stored.
//
// Parameters
//   DATA_W   result width from the logic unit
//   ADDR_W   register-file address width
//
// Ports
//   clk       single clock, all state updates on the rising edge
//   rst       asynchronous, active-high reset
//   in_valid  logic-unit result valid
//   in_ready  buffer can accept a result this cycle (registered)
//   in_data   logic-unit result
//   in_rd     destination register of the result
//   rf_we     register-file write request (buffer not empty)
//   rf_waddr  write address of the head entry (0 when empty)
//   rf_wdata  write data of the head entry (0 when empty)
//   rf_ready  register-file write port accepts this cycle
//   zero      (only with LOGIC_WB_ZERO_FLAG_EN) registered flag, set from
//             (in_data == 0) on every completed input handshake
//
// Configuration macro: LOGIC_WB_ZERO_FLAG_EN adds the zero flag port.
// ---------------------------------------------------------------------------
module logic_wb_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_rd,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic              rf_ready
`ifdef LOGIC_WB_ZERO_FLAG_EN
  ,
  output logic              zero
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic              wr_ptr;
  logic              rd_ptr;
  logic [ADDR_W-1:0] rd_mem   [2];
  logic [DATA_W-1:0] data_mem [2];

  logic              in_ready_q;
  logic              hs;
  logic              push;
  logic              pop;

  // A handshake with in_rd == 0 still completes; it simply stores nothing.
  assign hs   = in_valid & in_ready;
  assign push = hs & (in_rd != '0);
  assign pop  = rf_we & rf_ready;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: state_nxt gets a default before the case so every path assigns it;
  // otherwise synthesis infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY:   if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = FULL;
        else if (pop && !push) state_nxt = EMPTY;
      end
      FULL:    if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    rf_we    = (state != EMPTY);
    rf_waddr = '0;
    rf_wdata = '0;
    if (state != EMPTY) begin
      rf_waddr = rd_mem[rd_ptr];
      rf_wdata = data_mem[rd_ptr];
    end
    in_ready = in_ready_q;
  end

  // in_ready is registered from the next state: it stays low throughout
  // reset, rises on the first edge after release, and a pop out of FULL
  // re-raises it only on the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_ready_q <= 1'b0;
    else     in_ready_q <= (state_nxt != FULL);
  end

  // -------------------------------------------------------------------------
  // Storage and pointers (wrap modulo 2 by toggling)
  // -------------------------------------------------------------------------
  // NOTE: the two storage entries are cleared on reset so a discarded result
  // can never reappear on rf_wdata; a larger buffer would leave RAM unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      rd_mem[0]   <= '0;
      rd_mem[1]   <= '0;
      data_mem[0] <= '0;
      data_mem[1] <= '0;
    end else begin
      if (push) begin
        rd_mem[wr_ptr]   <= in_rd;
        data_mem[wr_ptr] <= in_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

`ifdef LOGIC_WB_ZERO_FLAG_EN
  // Updated on every completed handshake, including r0 results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     zero <= 1'b0;
    else if (hs) zero <= (in_data == '0);
  end
`endif

endmodule

// File: tb/tb_logic_wb_buffer.sv
// ---------------------------------------------------------------------------
// tb_logic_wb_buffer
//
// Self-checking bench for logic_wb_buffer (DATA_W = 32, ADDR_W = 5).
// A queue-based reference model tracks the buffered results; a compare
// process checks every output against it on each falling edge. Directed
// scenarios add literal expectations, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_logic_wb_buffer;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [ADDR_W-1:0] in_rd = '0;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_ready = 1'b0;
`ifdef LOGIC_WB_ZERO_FLAG_EN
  logic              zero;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic_wb_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_rd    (in_rd),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .rf_ready (rf_ready)
`ifdef LOGIC_WB_ZERO_FLAG_EN
    ,
    .zero     (zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: a FIFO of at most two results plus a ready flag that
  // follows the occupancy one edge late.
  // -------------------------------------------------------------------------
  ent_t q[$];
  bit   m_ready = 1'b0;
  bit   m_zero  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_ready = 1'b0;
      m_zero  = 1'b0;
    end else begin
      bit hs;
      hs = in_valid && m_ready;
      if (q.size() > 0 && rf_ready) void'(q.pop_front());
      if (hs && in_rd != 0) q.push_back('{rd: in_rd, data: in_data});
      if (hs) m_zero = (in_data == 0);
      m_ready = (q.size() < 2);
    end
  end

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    check("in_ready", 64'(in_ready), 64'(m_ready));
    check("rf_we",    64'(rf_we),    64'(q.size() > 0));
    check("rf_waddr", 64'(rf_waddr), (q.size() > 0) ? 64'(q[0].rd)   : 64'd0);
    check("rf_wdata", 64'(rf_wdata), (q.size() > 0) ? 64'(q[0].data) : 64'd0);
`ifdef LOGIC_WB_ZERO_FLAG_EN
    check("zero",     64'(zero),     64'(m_zero));
`endif
  end

  // Inputs change 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [ADDR_W-1:0] rd,
                       input logic [DATA_W-1:0] d);
    in_valid = v;
    in_rd    = rd;
    in_data  = d;
  endtask

  initial begin
    // Reset held: everything low.
    tick();
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_rf_we",    64'(rf_we),    64'd0);
    check("rst_waddr",    64'(rf_waddr), 64'd0);
    check("rst_wdata",    64'(rf_wdata), 64'd0);
    rst = 1'b0;
    tick();
    check("release_in_ready", 64'(in_ready), 64'd1);

    // Single push then immediate drain.
    rf_ready = 1'b1;
    drive(1'b1, 5'd3, 32'hA5A5_A5A5);
    tick();
    drive(1'b0, '0, '0);
    check("p1_we",    64'(rf_we),    64'd1);
    check("p1_waddr", 64'(rf_waddr), 64'd3);
    check("p1_wdata", 64'(rf_wdata), 64'hA5A5_A5A5);
    tick();
    check("p1_empty", 64'(rf_we),    64'd0);
    check("p1_waddr0", 64'(rf_waddr), 64'd0);

    // Fill to FULL with the write port stalled, then drain in order.
    rf_ready = 1'b0;
    drive(1'b1, 5'd1, 32'h11);
    tick();
    drive(1'b1, 5'd2, 32'h22);
    tick();
    drive(1'b0, '0, '0);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_waddr",    64'(rf_waddr), 64'd1);
    check("full_wdata",    64'(rf_wdata), 64'h11);
    tick();
    check("stall_hold",    64'(rf_wdata), 64'h11);
    rf_ready = 1'b1;
    tick();
    check("drain2_waddr",  64'(rf_waddr), 64'd2);
    check("drain2_wdata",  64'(rf_wdata), 64'h22);
    check("drain2_ready",  64'(in_ready), 64'd1);
    tick();
    check("drain_empty",   64'(rf_we),    64'd0);

    // r0 result: handshake completes, nothing stored.
    drive(1'b1, 5'd0, 32'hFFFF_FFFF);
    tick();
    drive(1'b0, '0, '0);
    check("r0_we",    64'(rf_we),    64'd0);
    check("r0_ready", 64'(in_ready), 64'd1);

    // Simultaneous push and pop in ONE.
    rf_ready = 1'b0;
    drive(1'b1, 5'd4, 32'h44);
    tick();
    rf_ready = 1'b1;
    drive(1'b1, 5'd5, 32'h55);
    tick();
    drive(1'b0, '0, '0);
    check("pp_we",    64'(rf_we),    64'd1);
    check("pp_waddr", 64'(rf_waddr), 64'd5);
    check("pp_wdata", 64'(rf_wdata), 64'h55);
    tick();
    check("pp_empty", 64'(rf_we),    64'd0);

    // Reset while FULL and stalled.
    rf_ready = 1'b0;
    drive(1'b1, 5'd6, 32'h66);
    tick();
    drive(1'b1, 5'd7, 32'h77);
    tick();
    drive(1'b0, '0, '0);
    check("pre_rst_full", 64'(in_ready), 64'd0);
    rst = 1'b1;
    #1;
    check("midrst_we",    64'(rf_we),    64'd0);
    check("midrst_waddr", 64'(rf_waddr), 64'd0);
    check("midrst_wdata", 64'(rf_wdata), 64'd0);
    check("midrst_ready", 64'(in_ready), 64'd0);
    tick();
    rst      = 1'b0;
    rf_ready = 1'b1;
    tick();
    check("postrst_we",    64'(rf_we),    64'd0);
    check("postrst_ready", 64'(in_ready), 64'd1);
    tick();
    check("postrst_we2",   64'(rf_we),    64'd0);

`ifdef LOGIC_WB_ZERO_FLAG_EN
    drive(1'b1, 5'd8, 32'd0);
    tick();
    check("zero_set", 64'(zero), 64'd1);
    drive(1'b1, 5'd0, 32'd7);
    tick();
    drive(1'b0, '0, '0);
    check("zero_clr", 64'(zero), 64'd0);
    tick();
`endif

    // Randomized traffic with occasional mid-run resets.
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      in_data  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      rf_ready = ($urandom_range(0, 2) != 0);
      rst      = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    drive(1'b0, '0, '0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_wb_buffer.md
LOGIC_WB_BUFFER -- requirements
Module: logic_wb_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, result width from the logic unit.
REQ-002 SHALL have parameter ADDR_W, default 5, register-file address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  logic-unit result valid.
REQ-006 SHALL have port in_ready  output  1  buffer can accept a result this cycle.
REQ-007 SHALL have port in_data  input  DATA_W  logic-unit result (dout).
REQ-008 SHALL have port in_rd  input  ADDR_W  destination register of the result.
REQ-009 SHALL have port rf_we  output  1  register-file write request.
REQ-010 SHALL have port rf_waddr  output  ADDR_W  register-file write address.
REQ-011 SHALL have port rf_wdata  output  DATA_W  register-file write data.
REQ-012 SHALL have port rf_ready  input  1  register-file write port accepts this cycle.

Function
REQ-013 SHALL implement a 2-entry in-order FIFO of {in_rd, in_data} between the logic unit and the register-file write port.
REQ-014 SHALL track occupancy as state EMPTY (0), ONE (1), FULL (2).
REQ-015 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in FULL; in_ready SHALL NOT depend combinationally on rf_ready or in_valid.
REQ-016 SHALL define push = in_valid & in_ready & (in_rd != 0); a handshake with in_rd == 0 completes but stores nothing (r0 writes discarded).
REQ-017 SHALL drive rf_we = 1 exactly when state != EMPTY, with rf_waddr/rf_wdata = head entry.
REQ-018 SHALL define pop = rf_we & rf_ready; the head is removed at that edge.
REQ-019 SHALL give a pushed entry latency of one cycle: pushed at edge N into EMPTY, rf_we high from edge N.
REQ-020 SHALL transition EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; ONE->ONE on simultaneous push and pop (new entry becomes head the next cycle); FULL->ONE on pop.
REQ-021 SHALL not push in FULL (in_ready = 0); a FULL pop SHALL re-raise in_ready the next cycle, not the same cycle.
REQ-022 SHALL drive rf_waddr and rf_wdata to 0 whenever state is EMPTY.
REQ-023 SHALL hold head outputs stable while rf_we = 1 and rf_ready = 0.
REQ-024 SHALL wrap read/write pointers modulo 2 with no loss or reordering across wrap.

Reset
REQ-025 SHALL, while rst = 1, force state EMPTY, both pointers 0, storage cleared, rf_we = 0, rf_waddr = 0, rf_wdata = 0, in_ready = 0.
REQ-026 SHALL raise in_ready on the first rising edge after rst deasserts.
REQ-027 SHALL discard all buffered entries on reset asserted mid-operation, with no partial write issued.

Configuration
REQ-028 SHALL, with macro LOGIC_WB_ZERO_FLAG_EN defined, add port zero  output  1, registered: on every completed handshake (including in_rd == 0) zero <= (in_data == 0); otherwise holds; reset value 0.
REQ-029 SHALL, without LOGIC_WB_ZERO_FLAG_EN, omit the zero port and its register; all other behaviour is identical.

Verification
REQ-030 SHALL cover: reset release, push rd=3 data=0xA5A5A5A5 with rf_ready=1 -> rf_we=1, rf_waddr=3, rf_wdata=0xA5A5A5A5 one cycle later, then EMPTY.
REQ-031 SHALL cover: rf_ready=0, push rd=1 0x11 and rd=2 0x22 -> FULL, in_ready=0; raise rf_ready -> writes 0x11 then 0x22 in order.
REQ-032 SHALL cover: push rd=0 data=0xFFFFFFFF -> handshake completes, rf_we stays 0, state EMPTY.
REQ-033 SHALL cover: in ONE, simultaneous push rd=5 0x55 and pop -> state stays ONE, next head rd=5 0x55.
REQ-034 SHALL cover: FULL with rf_ready=0, assert rst -> rf_we=0, outputs 0 immediately; no pending entry written after release.
REQ-035 SHALL cover, with LOGIC_WB_ZERO_FLAG_EN: push data=0 -> zero=1; push rd=0 data=7 -> zero=0.
